reg_status_tx: RTL and testbench

- UART transmit-side counterpart of the UART-driven register bank. It reports the live configuration of the GPS signal generator back to the host.
- On a request pulse it snapshots the register values and serializes a fixed 8-byte status frame as 8N1 UART on tx_out.
- It sits beside the register bank in the top level, sharing clk_in (16.368 MHz) and the baud setting.

---
 rtl/reg_status_tx_pkg.sv | 49 ++++
 rtl/reg_status_tx_if.sv | 27 ++
 rtl/reg_status_tx_uart_tx.sv | 115 +++++++++++
 rtl/reg_status_tx.sv | 145 ++++++++++++++
 tb/tb_reg_status_tx.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_status_tx_pkg.sv
// Shared definitions for the status-frame transmitter: frame layout offsets,
// defaults, sequencer/serializer state encodings and the checksum helper.
package reg_status_tx_pkg;

    // Frame geometry and defaults
    localparam int         FRAME_LEN            = 8;
    localparam int         CLKS_PER_BIT_DEFAULT = 142;     // 16368000 / 115200
    localparam logic [7:0] SYNC_BYTE_DEFAULT    = 8'hA5;

    // Byte offsets inside the status frame; the register bank uses the same
    // ordering for CTRL..SNR so host tools can share one table.
    localparam logic [2:0] OFS_SYNC        = 3'd0;
    localparam logic [2:0] OFS_CTRL        = 3'd1;
    localparam logic [2:0] OFS_SAT_ID      = 3'd2;
    localparam logic [2:0] OFS_DOPPLER     = 3'd3;
    localparam logic [2:0] OFS_CA_PHASE_LO = 3'd4;
    localparam logic [2:0] OFS_CA_PHASE_HI = 3'd5;
    localparam logic [2:0] OFS_SNR         = 3'd6;
    localparam logic [2:0] OFS_CSUM        = 3'd7;

    // Frame sequencer states, one-hot like the register bank FSM
    typedef enum logic [3:0] {
        SEQ_IDLE = 4'b0001,
        SEQ_SEND = 4'b0010,
        SEQ_WAIT = 4'b0100,
        SEQ_DONE = 4'b1000
    } seq_state_e;

    // UART transmitter states, one-hot
    typedef enum logic [3:0] {
        UTX_IDLE  = 4'b0001,
        UTX_START = 4'b0010,
        UTX_DATA  = 4'b0100,
        UTX_STOP  = 4'b1000
    } utx_state_e;

    // Checksum covers every payload byte (everything except sync and itself)
    function automatic logic [7:0] frame_csum(
        input logic [7:0] ctrl,
        input logic [7:0] sat,
        input logic [7:0] dop,
        input logic [7:0] ca_lo,
        input logic [7:0] ca_hi,
        input logic [7:0] snr
    );
        return ctrl ^ sat ^ dop ^ ca_lo ^ ca_hi ^ snr;
    endfunction

endpackage

// File: rtl/reg_status_tx_if.sv
// Host-facing signal bundle of the status transmitter: request, register
// values to report, and the serial line plus progress flags.
interface reg_status_tx_if;

    logic        send_in;
    logic [7:0]  ctrl_in;
    logic [4:0]  n_sat_in;
    logic [7:0]  doppler_in;
    logic [15:0] ca_phase_in;
    logic [7:0]  snr_in;
    logic        tx_out;
    logic        busy_out;
    logic        done_out;

    // Side that requests frames and supplies register values
    modport master (
        output send_in, ctrl_in, n_sat_in, doppler_in, ca_phase_in, snr_in,
        input  tx_out, busy_out, done_out
    );

    // The transmitter itself
    modport slave (
        input  send_in, ctrl_in, n_sat_in, doppler_in, ca_phase_in, snr_in,
        output tx_out, busy_out, done_out
    );

endinterface

// File: rtl/reg_status_tx_uart_tx.sv
// 8N1 UART byte serializer, the mirror of uart_rx. The line is driven from a
// flop that follows the state register by one cycle, so every bit lasts
// exactly CLKS_PER_BIT cycles and back-to-back bytes have no idle gap.
module uart_tx
    import reg_status_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk_in,
    input  logic       rst_in_n,
    input  logic       tx_start_in,
    input  logic [7:0] tx_data_in,
    output logic       tx_out,
    output logic       tx_busy_out,
    output logic       tx_done_out
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    utx_state_e        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    assign baud_end    = (baud_q == BAUD_LAST);
    assign tx_out      = tx_q;
    assign tx_busy_out = (state_q != UTX_IDLE);

    // Next-state, baud/bit counting and line level for the following cycle
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        data_d      = data_q;
        tx_done_out = 1'b0;
        tx_d        = 1'b1;

        case (state_q)
            UTX_IDLE: begin
                if (tx_start_in) begin
                    state_d = UTX_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    data_d  = tx_data_in;
                end
            end
            UTX_START: begin
                tx_d = 1'b0;
                if (baud_end) begin
                    state_d = UTX_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            UTX_DATA: begin
                tx_d = data_q[bit_q];
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UTX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            UTX_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    tx_done_out = 1'b1;
                    baud_d      = '0;
                    // A start in the final stop cycle chains the next byte directly
                    if (tx_start_in) begin
                        state_d = UTX_START;
                        bit_d   = '0;
                        data_d  = tx_data_in;
                    end else begin
                        state_d = UTX_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = UTX_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase
    end

    // State and line registers; reset forces the line idle immediately
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q <= UTX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/reg_status_tx.sv
// Status frame transmitter: snapshots the generator configuration on request
// and sends SYNC, CTRL, SAT_ID, DOPPLER, CA_LO, CA_HI, SNR, XOR checksum.
module reg_status_tx
    import reg_status_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic           clk_in,
    input  logic           rst_in_n,
    reg_status_tx_if.slave bus
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    seq_state_e  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  snap_ctrl_q, snap_ctrl_d;
    logic [4:0]  snap_sat_q, snap_sat_d;
    logic [7:0]  snap_dop_q, snap_dop_d;
    logic [15:0] snap_ca_q, snap_ca_d;
    logic [7:0]  snap_snr_q, snap_snr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        tx_start;
    logic [2:0]  issue_idx;
    logic [7:0]  tx_byte;
    logic [7:0]  csum;
    logic        uart_busy;
    logic        uart_done;

    assign bus.busy_out = busy_q;
    assign bus.done_out = done_q;

    // Sequencer: accept a request, issue bytes in order, chain on byte-done
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_ctrl_d = snap_ctrl_q;
        snap_sat_d  = snap_sat_q;
        snap_dop_d  = snap_dop_q;
        snap_ca_d   = snap_ca_q;
        snap_snr_d  = snap_snr_q;
        tx_start    = 1'b0;
        issue_idx   = idx_q;

        case (state_q)
            SEQ_IDLE: begin
                if (bus.send_in) begin
                    snap_ctrl_d = bus.ctrl_in;
                    snap_sat_d  = bus.n_sat_in;
                    snap_dop_d  = bus.doppler_in;
                    snap_ca_d   = bus.ca_phase_in;
                    snap_snr_d  = bus.snr_in;
                    idx_d       = '0;
                    state_d     = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                if (!uart_busy) begin
                    tx_start = 1'b1;
                    state_d  = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (uart_done) begin
                    if (idx_q != LAST_IDX) begin
                        // Hand over the next byte in the serializer's final stop cycle
                        idx_d     = idx_q + 3'd1;
                        issue_idx = idx_q + 3'd1;
                        tx_start  = 1'b1;
                    end else begin
                        state_d = SEQ_DONE;
                    end
                end
            end
            SEQ_DONE: begin
                state_d = SEQ_IDLE;
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase

        busy_d = (state_q == SEQ_SEND) || (state_q == SEQ_WAIT);
        done_d = (state_q == SEQ_DONE);
    end

    // Frame byte selection from the snapshot
    always_comb begin
        csum    = frame_csum(snap_ctrl_q, {3'b000, snap_sat_q}, snap_dop_q,
                             snap_ca_q[7:0], snap_ca_q[15:8], snap_snr_q);
        tx_byte = SYNC_BYTE;
        case (issue_idx)
            OFS_SYNC:        tx_byte = SYNC_BYTE;
            OFS_CTRL:        tx_byte = snap_ctrl_q;
            OFS_SAT_ID:      tx_byte = {3'b000, snap_sat_q};
            OFS_DOPPLER:     tx_byte = snap_dop_q;
            OFS_CA_PHASE_LO: tx_byte = snap_ca_q[7:0];
            OFS_CA_PHASE_HI: tx_byte = snap_ca_q[15:8];
            OFS_SNR:         tx_byte = snap_snr_q;
            OFS_CSUM:        tx_byte = csum;
            default:         tx_byte = SYNC_BYTE;
        endcase
    end

    // Sequencer, snapshot and flag registers
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            state_q     <= SEQ_IDLE;
            idx_q       <= '0;
            snap_ctrl_q <= '0;
            snap_sat_q  <= '0;
            snap_dop_q  <= '0;
            snap_ca_q   <= '0;
            snap_snr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_ctrl_q <= snap_ctrl_d;
            snap_sat_q  <= snap_sat_d;
            snap_dop_q  <= snap_dop_d;
            snap_ca_q   <= snap_ca_d;
            snap_snr_q  <= snap_snr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk_in      (clk_in),
        .rst_in_n    (rst_in_n),
        .tx_start_in (tx_start),
        .tx_data_in  (tx_byte),
        .tx_out      (bus.tx_out),
        .tx_busy_out (uart_busy),
        .tx_done_out (uart_done)
    );

endmodule

// File: tb/tb_reg_status_tx.sv
// Directed bench for reg_status_tx: frame content, bit timing, snapshot,
// busy-time requests, mid-frame reset, boundary values and default baud.
module tb_reg_status_tx;

    localparam int C         = 4;
    localparam int FRAME_CYC = 80 * C;
    localparam int CAP_N     = FRAME_CYC + 10;

    logic clk_in = 1'b0;
    logic rst_in_n;
    int   total = 0;
    int   bad   = 0;

    logic tx_s   [0:511];
    logic busy_s [0:511];
    logic done_s [0:511];
    int   act_kind, act_at1, act_at2;

    always #5 clk_in = ~clk_in;

    reg_status_tx_if bus();
    reg_status_tx_if bus_def();

    reg_status_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .bus      (bus)
    );

    reg_status_tx dut_def (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .bus      (bus_def)
    );

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Request a frame; sample j is taken 1 ns after edge k+j (edge k accepts)
    task automatic start_and_capture;
        bus.send_in = 1'b1;
        tick;
        for (int j = 1; j <= CAP_N; j++) begin
            bus.send_in = (act_kind == 2) && (j == act_at1 || j == act_at2);
            if (act_kind == 1 && j == act_at1) bus.doppler_in = 8'h55;
            tick;
            tx_s[j]   = bus.tx_out;
            busy_s[j] = bus.busy_out;
            done_s[j] = bus.done_out;
        end
        bus.send_in = 1'b0;
    endtask

    // Decode the captured line; byte b lives at exp[8*b +: 8]
    task automatic check_frame(input string name, input logic [63:0] exp);
        int         busy_n;
        int         done_n;
        int         base;
        logic [9:0] bits;
        logic       width_ok;
        check({name, ":tx_after_k1"}, 32'(tx_s[1]), 32'd1);
        check({name, ":tx_after_k2"}, 32'(tx_s[2]), 32'd0);
        for (int b = 0; b < 8; b++) begin
            width_ok = 1'b1;
            bits     = '0;
            for (int i = 0; i < 10; i++) begin
                base    = 2 + (10 * b + i) * C;
                bits[i] = tx_s[base];
                for (int m = 1; m < C; m++)
                    if (tx_s[base + m] !== tx_s[base]) width_ok = 1'b0;
            end
            check($sformatf("%s:byte%0d", name, b), 32'(bits[8:1]), 32'(exp[8*b +: 8]));
            check($sformatf("%s:stop_start%0d", name, b), 32'({bits[9], bits[0]}), 32'd2);
            check($sformatf("%s:bit_width%0d", name, b), 32'(width_ok), 32'd1);
        end
        busy_n = 0;
        done_n = 0;
        for (int j = 1; j <= CAP_N; j++) begin
            busy_n += int'(busy_s[j]);
            done_n += int'(done_s[j]);
        end
        check({name, ":busy_cycles"}, 32'(busy_n), 32'(FRAME_CYC + 1));
        check({name, ":done_count"}, 32'(done_n), 32'd1);
        check({name, ":done_pos"}, 32'(done_s[FRAME_CYC + 2]), 32'd1);
        check({name, ":idle_after"}, 32'(tx_s[FRAME_CYC + 2]), 32'd1);
    endtask

    initial begin
        int busy_hits;
        int rise1, rise2, t_fall, t_done;
        logic prev_busy, got_done;

        rst_in_n            = 1'b0;
        act_kind            = 0;
        act_at1             = 0;
        act_at2             = 0;
        bus.send_in         = 1'b0;
        bus.ctrl_in         = 8'h00;
        bus.n_sat_in        = 5'h00;
        bus.doppler_in      = 8'h00;
        bus.ca_phase_in     = 16'h0000;
        bus.snr_in          = 8'h00;
        bus_def.send_in     = 1'b0;
        bus_def.ctrl_in     = 8'h00;
        bus_def.n_sat_in    = 5'h00;
        bus_def.doppler_in  = 8'h00;
        bus_def.ca_phase_in = 16'h0000;
        bus_def.snr_in      = 8'h00;

        // Reset state
        repeat (3) tick;
        check("rst:tx", 32'(bus.tx_out), 32'd1);
        check("rst:busy", 32'(bus.busy_out), 32'd0);
        check("rst:done", 32'(bus.done_out), 32'd0);
        rst_in_n = 1'b1;
        repeat (2) tick;

        // Basic frame
        bus.ctrl_in     = 8'h02;
        bus.n_sat_in    = 5'h05;
        bus.doppler_in  = 8'hC0;
        bus.ca_phase_in = 16'h1234;
        bus.snr_in      = 8'h10;
        start_and_capture;
        check_frame("basic", {8'hF1, 8'h10, 8'h12, 8'h34, 8'hC0, 8'h05, 8'h02, 8'hA5});
        $display("basic frame: checked bytes A5 02 05 C0 34 12 10 F1");

        // Snapshot: doppler changes mid-frame
        act_kind = 1;
        act_at1  = 100;
        start_and_capture;
        check_frame("snap1", {8'hF1, 8'h10, 8'h12, 8'h34, 8'hC0, 8'h05, 8'h02, 8'hA5});
        act_kind = 0;
        start_and_capture;
        check_frame("snap2", {8'h64, 8'h10, 8'h12, 8'h34, 8'h55, 8'h05, 8'h02, 8'hA5});
        $display("snapshot: in-flight frame kept C0, next frame carried 55");

        // Requests while busy are dropped
        act_kind = 2;
        act_at1  = 50;
        act_at2  = 200;
        start_and_capture;
        check_frame("busyreq", {8'h64, 8'h10, 8'h12, 8'h34, 8'h55, 8'h05, 8'h02, 8'hA5});
        act_kind  = 0;
        busy_hits = 0;
        for (int j = 0; j < 20; j++) begin
            tick;
            busy_hits += int'(bus.busy_out) + int'(!bus.tx_out) + int'(bus.done_out);
        end
        check("busyreq:no_second_frame", 32'(busy_hits), 32'd0);
        $display("request while busy: single frame emitted");

        // Reset during byte 3 (sample 130 is data bit 1 of 0x55, line low)
        bus.send_in = 1'b1;
        tick;
        bus.send_in = 1'b0;
        for (int j = 1; j <= 130; j++) tick;
        rst_in_n = 1'b0;
        #1;
        check("rstmid:tx", 32'(bus.tx_out), 32'd1);
        check("rstmid:busy", 32'(bus.busy_out), 32'd0);
        check("rstmid:done", 32'(bus.done_out), 32'd0);
        repeat (2) tick;
        check("rstmid:held_done", 32'(bus.done_out), 32'd0);
        check("rstmid:held_tx", 32'(bus.tx_out), 32'd1);
        rst_in_n = 1'b1;
        tick;
        start_and_capture;
        check_frame("after_rst", {8'h64, 8'h10, 8'h12, 8'h34, 8'h55, 8'h05, 8'h02, 8'hA5});
        $display("reset mid-frame: aborted, following frame complete");

        // Boundary values
        bus.ctrl_in     = 8'hFF;
        bus.n_sat_in    = 5'h1F;
        bus.doppler_in  = 8'hFF;
        bus.ca_phase_in = 16'hFFFF;
        bus.snr_in      = 8'hFF;
        start_and_capture;
        check_frame("boundary", {8'hE0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 8'hFF, 8'hA5});
        $display("boundary: byte2=1F checksum=E0");

        // send_in held high: frames restart every 80*C+3 cycles
        bus.send_in = 1'b1;
        rise1       = -1;
        rise2       = -1;
        prev_busy   = bus.busy_out;
        for (int j = 1; j <= 800 && rise2 < 0; j++) begin
            tick;
            if (bus.busy_out && !prev_busy) begin
                if (rise1 < 0) rise1 = j;
                else           rise2 = j;
            end
            prev_busy = bus.busy_out;
        end
        bus.send_in = 1'b0;
        check("cont:first_busy", 32'(rise1), 32'd2);
        check("cont:period", 32'(rise2 - rise1), 32'(FRAME_CYC + 3));
        got_done = 1'b0;
        for (int j = 0; j < 800 && !got_done; j++) begin
            tick;
            got_done = bus.done_out;
        end
        check("cont:final_done", 32'(got_done), 32'd1);
        tick;
        $display("continuous send: period %0d cycles", rise2 - rise1);

        // Default 142 cycles per bit: line time of a full frame
        bus_def.ctrl_in     = 8'h02;
        bus_def.n_sat_in    = 5'h05;
        bus_def.doppler_in  = 8'hC0;
        bus_def.ca_phase_in = 16'h1234;
        bus_def.snr_in      = 8'h10;
        bus_def.send_in     = 1'b1;
        tick;
        bus_def.send_in = 1'b0;
        t_fall = -1;
        t_done = -1;
        for (int j = 1; j <= 12000 && t_done < 0; j++) begin
            tick;
            if (t_fall < 0 && bus_def.tx_out == 1'b0) t_fall = j;
            if (bus_def.done_out) t_done = j;
        end
        check("default:start_latency", 32'(t_fall), 32'd2);
        check("default:frame_cycles", 32'(t_done - t_fall), 32'd11360);
        $display("default baud: frame spans %0d cycles", t_done - t_fall);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
